// File: rtl/alchitry_top_pkg.sv
// Shared UART definitions for the Alchitry echo top and its receiver:
// bit-period helper, FSM state encoding and frame shape.
package alchitry_top_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;
    localparam int CNT_W     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/alchitry_top_core_if.sv
// UART and status LED pins of the Alchitry echo top.
// The design drives through master; the board or bench uses slave.
interface alchitry_top_core_if;
    logic       usb_rx;
    logic       usb_tx;
    logic [7:0] led;

    modport master (input usb_rx, output usb_tx, output led);
    modport slave  (output usb_rx, input usb_tx, input led);
endinterface

// File: rtl/alchitry_top_core_uart_rx.sv
// UART receiver: two-flop synchronizer, mid-bit sampling FSM and a
// one-cycle rx_valid strobe for each byte with a good stop bit.
module uart_rx
    import alchitry_top_pkg::*;
#(
    parameter int CLKS_PER_BIT = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       rx_valid,
    output logic [7:0] rx_byte
);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic             sync1_r, sync2_r;
    uart_state_e      state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [2:0]       bit_r, bit_s;
    logic [7:0]       shift_r, shift_s;
    logic             ferr_r, ferr_s;
    logic             valid_s, valid_r;
    logic [7:0]       byte_r;

    // State, datapath and synchronizer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            state_r <= IDLE;
            cnt_r   <= '0;
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
            ferr_r  <= 1'b0;
            valid_r <= 1'b0;
            byte_r  <= 8'h00;
        end else begin
            sync1_r <= rx;
            sync2_r <= sync1_r;
            state_r <= state_s;
            cnt_r   <= cnt_s;
            bit_r   <= bit_s;
            shift_r <= shift_s;
            ferr_r  <= ferr_s;
            valid_r <= valid_s;
            byte_r  <= valid_s ? shift_r : byte_r;
        end
    end

    // Next-state logic; a low stop bit parks in STOP until the line idles high
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        bit_s   = bit_r;
        shift_s = shift_r;
        ferr_s  = ferr_r;
        valid_s = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_s  = '0;
                ferr_s = 1'b0;
                if (!sync2_r) state_s = START;
                else          state_s = IDLE;
            end
            START: begin
                if (cnt_r == HALF_M1) begin
                    cnt_s   = '0;
                    bit_s   = 3'd0;
                    state_s = sync2_r ? IDLE : DATA;
                end else begin
                    cnt_s = cnt_r + 1'b1;
                end
            end
            DATA: begin
                if (cnt_r == FULL_M1) begin
                    cnt_s   = '0;
                    shift_s = {sync2_r, shift_r[7:1]};
                    if (bit_r == 3'(DATA_BITS - 1)) state_s = STOP;
                    else                            bit_s   = bit_r + 3'd1;
                end else begin
                    cnt_s = cnt_r + 1'b1;
                end
            end
            STOP: begin
                if (cnt_r == FULL_M1) begin
                    if (sync2_r) begin
                        valid_s = !ferr_r;
                        state_s = IDLE;
                    end else begin
                        ferr_s = 1'b1;
                    end
                end else begin
                    cnt_s = cnt_r + 1'b1;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    assign rx_valid = valid_r;
    assign rx_byte  = byte_r;

endmodule

// File: rtl/alchitry_top_core.sv
// Alchitry board top reduced to a UART echo with last-byte LEDs; FT245 pins parked.
// Optional ALCHITRY_TOP_HEARTBEAT_EN puts a heartbeat counter MSB on led[7].
module alchitry_top_core
    import alchitry_top_pkg::*;
#(
    parameter int CLK_HZ  = 100000000,
    parameter int BAUD    = 1000000,
    parameter int HB_BITS = 26
) (
    input  logic               clk,
    input  logic               rst,
    alchitry_top_core_if.master uart,
    input  logic               ft_clk,
    input  logic               ft_rxf,
    input  logic               ft_txe,
    inout  wire  [15:0]        ft_data,
    inout  wire  [1:0]         ft_be,
    output logic               ft_rd,
    output logic               ft_wr,
    output logic               ft_oe,
    output logic               ft_wakeup,
    output logic               ft_reset
);
    localparam int               CPB     = clks_per_bit(CLK_HZ, BAUD);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] STOP_M1 = CNT_W'(CPB * STOP_BITS - 1);

    logic             rx_valid_s;
    logic [7:0]       rx_byte_s;
    logic             hold_full_r;
    logic [7:0]       hold_byte_r;
    logic [7:0]       led_r;
    uart_state_e      tx_state_r, tx_state_s;
    logic [CNT_W-1:0] tx_cnt_r, tx_cnt_s;
    logic [2:0]       tx_bit_r, tx_bit_s;
    logic [7:0]       tx_shift_r, tx_shift_s;
    logic             usb_tx_r, usb_tx_s;
    logic             take_s;

    uart_rx #(.CLKS_PER_BIT(CPB)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rx       (uart.usb_rx),
        .rx_valid (rx_valid_s),
        .rx_byte  (rx_byte_s)
    );

    // Echo holding register and last-byte LED latch; a byte arriving while full is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full_r <= 1'b0;
            hold_byte_r <= 8'h00;
            led_r       <= 8'h00;
        end else begin
            led_r <= rx_valid_s ? rx_byte_s : led_r;
            if (rx_valid_s && !hold_full_r) begin
                hold_full_r <= 1'b1;
                hold_byte_r <= rx_byte_s;
            end else if (take_s) begin
                hold_full_r <= 1'b0;
            end else begin
                hold_full_r <= hold_full_r;
            end
        end
    end

    // TX serializer registers; usb_tx is the registered line value
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_r <= IDLE;
            tx_cnt_r   <= '0;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'h00;
            usb_tx_r   <= 1'b1;
        end else begin
            tx_state_r <= tx_state_s;
            tx_cnt_r   <= tx_cnt_s;
            tx_bit_r   <= tx_bit_s;
            tx_shift_r <= tx_shift_s;
            usb_tx_r   <= usb_tx_s;
        end
    end

    // TX next-state; end of STOP chains straight into the next START when a byte waits
    always_comb begin
        tx_state_s = tx_state_r;
        tx_cnt_s   = tx_cnt_r;
        tx_bit_s   = tx_bit_r;
        tx_shift_s = tx_shift_r;
        usb_tx_s   = usb_tx_r;
        take_s     = 1'b0;
        case (tx_state_r)
            IDLE: begin
                if (hold_full_r) begin
                    take_s     = 1'b1;
                    tx_shift_s = hold_byte_r;
                    tx_cnt_s   = '0;
                    usb_tx_s   = 1'b0;
                    tx_state_s = START;
                end else begin
                    usb_tx_s = 1'b1;
                end
            end
            START: begin
                if (tx_cnt_r == FULL_M1) begin
                    tx_cnt_s   = '0;
                    tx_bit_s   = 3'd0;
                    usb_tx_s   = tx_shift_r[0];
                    tx_state_s = DATA;
                end else begin
                    tx_cnt_s = tx_cnt_r + 1'b1;
                end
            end
            DATA: begin
                if (tx_cnt_r == FULL_M1) begin
                    tx_cnt_s = '0;
                    if (tx_bit_r == 3'(DATA_BITS - 1)) begin
                        usb_tx_s   = 1'b1;
                        tx_state_s = STOP;
                    end else begin
                        tx_bit_s   = tx_bit_r + 3'd1;
                        tx_shift_s = {1'b0, tx_shift_r[7:1]};
                        usb_tx_s   = tx_shift_r[1];
                    end
                end else begin
                    tx_cnt_s = tx_cnt_r + 1'b1;
                end
            end
            STOP: begin
                if (tx_cnt_r == STOP_M1) begin
                    tx_cnt_s = '0;
                    if (hold_full_r) begin
                        take_s     = 1'b1;
                        tx_shift_s = hold_byte_r;
                        usb_tx_s   = 1'b0;
                        tx_state_s = START;
                    end else begin
                        usb_tx_s   = 1'b1;
                        tx_state_s = IDLE;
                    end
                end else begin
                    tx_cnt_s = tx_cnt_r + 1'b1;
                end
            end
            default: begin
                usb_tx_s   = 1'b1;
                tx_state_s = IDLE;
            end
        endcase
    end

    assign uart.usb_tx = usb_tx_r;

`ifdef ALCHITRY_TOP_HEARTBEAT_EN
    logic [HB_BITS-1:0] hb_r;
    logic               unused_s;

    // Free-running heartbeat counter
    always_ff @(posedge clk) begin
        if (rst) hb_r <= '0;
        else     hb_r <= hb_r + 1'b1;
    end

    assign uart.led = {hb_r[HB_BITS-1], led_r[6:0]};
    assign unused_s = ^{ft_clk, ft_rxf, ft_txe, led_r[7]};
`else
    logic unused_s;

    assign uart.led = led_r;
    assign unused_s = ^{ft_clk, ft_rxf, ft_txe, 32'(HB_BITS)};
`endif

    // FT245 interface parked: bus released, active-low strobes deasserted
    assign ft_data   = {16{1'bz}};
    assign ft_be     = {2{1'bz}};
    assign ft_rd     = 1'b1;
    assign ft_wr     = 1'b1;
    assign ft_oe     = 1'b1;
    assign ft_wakeup = 1'b1;
    assign ft_reset  = 1'b1;

endmodule

// File: tb/tb_alchitry_top_core.sv
// Directed bench for alchitry_top_core: reset, echo, false start, framing error,
// back-to-back frames and mid-frame reset, with a free-running usb_tx frame decoder.
module tb_alchitry_top_core;
    localparam int CPB = 100;
`ifdef ALCHITRY_TOP_HEARTBEAT_EN
    localparam logic [7:0] LED_MASK = 8'h7F;
`else
    localparam logic [7:0] LED_MASK = 8'hFF;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ft_clk, ft_rxf, ft_txe;
    wire  [15:0] ft_data;
    wire  [1:0]  ft_be;
    logic        ft_rd, ft_wr, ft_oe, ft_wakeup, ft_reset;

    alchitry_top_core_if uart();

    alchitry_top_core #(.CLK_HZ(100000000), .BAUD(1000000), .HB_BITS(26)) dut (
        .clk       (clk),
        .rst       (rst),
        .uart      (uart),
        .ft_clk    (ft_clk),
        .ft_rxf    (ft_rxf),
        .ft_txe    (ft_txe),
        .ft_data   (ft_data),
        .ft_be     (ft_be),
        .ft_rd     (ft_rd),
        .ft_wr     (ft_wr),
        .ft_oe     (ft_oe),
        .ft_wakeup (ft_wakeup),
        .ft_reset  (ft_reset)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Cycle of the most recent led change, seen on the falling edge
    logic [7:0] led_prev = 8'h00;
    int         led_chg_cyc = -1;
    always @(negedge clk) begin
        led_prev <= uart.led;
        if (uart.led !== led_prev) led_chg_cyc <= cyc;
    end

    // usb_tx decoder: bit i of each entry is the i-th bit-centre sample (start first)
    logic [9:0] q_bits[$];
    int         q_start[$];
    int         fall_cnt = 0;
    initial begin : tx_decoder
        logic [9:0] bits;
        int         st;
        forever begin
            @(negedge clk);
            if (uart.usb_tx === 1'b0) begin
                st = cyc;
                fall_cnt++;
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 10; i++) begin
                    bits[i] = uart.usb_tx;
                    if (i < 9) repeat (CPB) @(negedge clk);
                end
                q_bits.push_back(bits);
                q_start.push_back(st);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart.usb_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart.usb_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart.usb_rx = stop;
        repeat (CPB) @(negedge clk);
        uart.usb_rx = 1'b1;
    endtask

    task automatic clear_q();
        q_bits.delete();
        q_start.delete();
    endtask

    initial begin
        int fc;
        int k;
        rst         = 1'b1;
        uart.usb_rx = 1'b1;
        ft_clk      = 1'b0;
        ft_rxf      = 1'b1;
        ft_txe      = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rst_ft_pins", {27'd0, ft_rd, ft_wr, ft_oe, ft_wakeup, ft_reset}, 32'h1F);
            chk("rst_usb_tx", {31'd0, uart.usb_tx}, 32'd1);
        end
        chk("rst_led", {24'd0, uart.led}, 32'h00);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        clear_q();

        // Echo of A5
        send_byte(8'hA5, 1'b1);
        repeat (1200) @(negedge clk);
        chk("echo_led", {24'd0, uart.led & LED_MASK}, {24'd0, 8'hA5 & LED_MASK});
        chk("echo_count", q_bits.size(), 32'd1);
        if (q_bits.size() > 0) begin
            chk("echo_bits", {22'd0, q_bits[0]}, {22'd0, 10'b11_0100_1010});
            chk("echo_latency", {31'd0, (q_start[0] - led_chg_cyc) inside {[0:2]}}, 32'd1);
        end
        clear_q();

        // False start: 30-cycle low glitch
        uart.usb_rx = 1'b0;
        repeat (30) @(negedge clk);
        uart.usb_rx = 1'b1;
        repeat (300) @(negedge clk);
        chk("false_led", {24'd0, uart.led & LED_MASK}, {24'd0, 8'hA5 & LED_MASK});
        chk("false_count", q_bits.size(), 32'd0);
        chk("false_usb_tx", {31'd0, uart.usb_tx}, 32'd1);

        // Framing error on 3C
        send_byte(8'h3C, 1'b0);
        repeat (1200) @(negedge clk);
        chk("ferr_led", {24'd0, uart.led & LED_MASK}, {24'd0, 8'hA5 & LED_MASK});
        chk("ferr_count", q_bits.size(), 32'd0);
        clear_q();

        // Back-to-back 01, FF
        send_byte(8'h01, 1'b1);
        send_byte(8'hFF, 1'b1);
        repeat (2500) @(negedge clk);
        chk("b2b_count", q_bits.size(), 32'd2);
        if (q_bits.size() > 1) begin
            chk("b2b_first", {22'd0, q_bits[0]}, 32'h202);
            chk("b2b_second", {22'd0, q_bits[1]}, 32'h3FE);
            chk("b2b_spacing", q_start[1] - q_start[0], 32'd1000);
        end
        chk("b2b_led", {24'd0, uart.led & LED_MASK}, {24'd0, 8'hFF & LED_MASK});
        clear_q();

        // Mid-frame reset during data bit 4 of the 0F echo
        fc = fall_cnt;
        fork
            send_byte(8'h0F, 1'b1);
        join_none
        k = 0;
        while (k < 3000 && fall_cnt == fc) begin
            @(negedge clk);
            k++;
        end
        chk("mid_fall_seen", {31'd0, fall_cnt != fc}, 32'd1);
        repeat (5 * CPB + CPB / 2 - 5) @(negedge clk);
        chk("mid_pre_tx", {31'd0, uart.usb_tx}, 32'd0);
        chk("mid_pre_led", {24'd0, uart.led & LED_MASK}, {24'd0, 8'h0F & LED_MASK});
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_tx", {31'd0, uart.usb_tx}, 32'd1);
        chk("mid_rst_led", {24'd0, uart.led}, 32'h00);
        @(negedge clk);
        rst = 1'b0;
        repeat (1500) @(negedge clk);
        chk("mid_idle_tx", {31'd0, uart.usb_tx}, 32'd1);
        clear_q();

        send_byte(8'h5A, 1'b1);
        repeat (1200) @(negedge clk);
        chk("post_count", q_bits.size(), 32'd1);
        if (q_bits.size() > 0) begin
            chk("post_bits", {22'd0, q_bits[0]}, 32'h2B4);
        end
        chk("post_led", {24'd0, uart.led & LED_MASK}, {24'd0, 8'h5A & LED_MASK});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
